autenticacao_verificador: RTL

Receiving end of the 7-bit authentication codeword link. It latches a 3-bit key selector, deserialises a 7-bit codeword sent MSB first, and compares it against the expected codeword for that selector. It reports grant or deny, counts consecutive failures, and enforces a timed lockout. It sits between the serial code input path and the access-control logic.

---
 rtl/autenticacao_pkg.sv | 28 ++
 rtl/autenticacao_deserializador.sv | 62 ++++++
 rtl/autenticacao_verificador.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/autenticacao_pkg.sv
// Shared definitions for the authentication codeword receiver.
//   state_t        : receiver FSM states
//   CODE_W, SEL_W  : codeword and key-selector widths
//   expected_code  : codeword the sender must transmit for a given selector
package autenticacao_pkg;

    localparam int CODE_W = 7;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_t;

    // sel = {A, B, C}; E = {1, A^B, C, C, A&~B, 1, A&~B}
    function automatic logic [CODE_W-1:0] expected_code(input logic [SEL_W-1:0] sel);
        logic a_s;
        logic b_s;
        logic c_s;
        a_s = sel[2];
        b_s = sel[1];
        c_s = sel[0];
        expected_code = {1'b1, a_s ^ b_s, c_s, c_s, a_s & ~b_s, 1'b1, a_s & ~b_s};
    endfunction

endpackage

// File: rtl/autenticacao_deserializador.sv
// Serial-to-parallel front end for one codeword frame.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : restart the frame (shift register and both counters to 0)
//   enable     : frame reception active this cycle
//   bit_in     : serial bit, MSB first
//   bit_valid  : bit_in valid this cycle
//   code       : bits collected so far (last bit at LSB)
//   done       : this cycle's bit completes the codeword
//   timeout    : this idle cycle exhausts the inter-bit budget
module autenticacao_deserializador
    import autenticacao_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [CODE_W-1:0] code,
    output logic              done,
    output logic              timeout
);

    localparam int BIT_CNT_W = $clog2(CODE_W + 1);
    localparam int TO_W      = $clog2(TIMEOUT + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(CODE_W - 1);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);

    logic [CODE_W-1:0]    shift_r;
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic [TO_W-1:0]      to_cnt_r;

    // Shift register, bit counter and inter-bit timeout counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r   <= {CODE_W{1'b0}};
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
        end else if (clear) begin
            shift_r   <= {CODE_W{1'b0}};
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            to_cnt_r  <= {TO_W{1'b0}};
        end else if (enable) begin
            if (bit_valid) begin
                shift_r   <= {shift_r[CODE_W-2:0], bit_in};
                bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                to_cnt_r  <= {TO_W{1'b0}};
            end else begin
                to_cnt_r  <= to_cnt_r + TO_W'(1);
            end
        end
    end

    assign code = shift_r;
    // Flags fire on the edge that would make the count reach its limit,
    // so the FSM leaves RECV on exactly that edge.
    assign done    = enable && bit_valid && (bit_cnt_r == LAST_BIT);
    assign timeout = enable && !bit_valid && (to_cnt_r == TO_LAST);

endmodule

// File: rtl/autenticacao_verificador.sv
// Authentication codeword verifier: latches a key selector, receives a
// 7-bit codeword, grants or denies, and locks out after repeated denials.
//   clk, rst          : clock, asynchronous active-high reset
//   start, A, B, C    : frame start and key selector {A,B,C}
//   bit_in, bit_valid : serial codeword, MSB first
//   granted/denied/aborted : one-cycle result pulses
//   busy              : frame in RECV or CHECK
//   locked            : lockout in progress
//   fail_cnt          : consecutive-denial count
module autenticacao_verificador
    import autenticacao_pkg::*;
#(
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          A,
    input  logic                          B,
    input  logic                          C,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          granted,
    output logic                          denied,
    output logic                          aborted,
    output logic                          busy,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAIL);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);

    state_t             state_r, state_s;
    logic [SEL_W-1:0]   sel_r, sel_s;
    logic [FAIL_W-1:0]  fail_cnt_r, fail_cnt_s, fail_inc_s;
    logic [LOCK_W-1:0]  lock_cnt_r, lock_cnt_s;
    logic               granted_r, granted_s;
    logic               denied_r, denied_s;
    logic               aborted_r, aborted_s;
    logic               busy_r, busy_s;
    logic               locked_r, locked_s;

    logic               clear_s, enable_s, done_s, timeout_s, match_s;
    logic [CODE_W-1:0]  code_s;

    // start is honoured only in IDLE and RECV, and a coincident bit is dropped
    assign clear_s  = start && ((state_r == IDLE) || (state_r == RECV));
    assign enable_s = (state_r == RECV) && !start;
    assign match_s  = (code_s == expected_code(sel_r));
    assign fail_inc_s = (fail_cnt_r == FAIL_MAX) ? fail_cnt_r : fail_cnt_r + FAIL_W'(1);

    autenticacao_deserializador #(
        .TIMEOUT (TIMEOUT)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .enable    (enable_s),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .code      (code_s),
        .done      (done_s),
        .timeout   (timeout_s)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RECV;
                else       state_s = IDLE;
            end
            RECV: begin
                if (start)          state_s = RECV;
                else if (done_s)    state_s = CHECK;
                else if (timeout_s) state_s = IDLE;
                else                state_s = RECV;
            end
            CHECK: begin
                if (match_s)                  state_s = IDLE;
                else if (fail_inc_s == FAIL_MAX) state_s = LOCKED;
                else                          state_s = IDLE;
            end
            LOCKED: begin
                if (lock_cnt_r <= LOCK_ONE) state_s = IDLE;
                else                        state_s = LOCKED;
            end
            default: state_s = IDLE;
        endcase
    end

    // Next values of outputs, selector, fail counter and lock counter
    always_comb begin
        granted_s  = (state_r == CHECK) && match_s;
        denied_s   = (state_r == CHECK) && !match_s;
        aborted_s  = timeout_s;
        // Decoding the next state keeps busy/locked aligned with the state itself
        busy_s     = (state_s == RECV) || (state_s == CHECK);
        locked_s   = (state_s == LOCKED);
        sel_s      = sel_r;
        fail_cnt_s = fail_cnt_r;
        lock_cnt_s = lock_cnt_r;
        if (clear_s) begin
            sel_s = {A, B, C};
        end else begin
            sel_s = sel_r;
        end
        case (state_r)
            CHECK: begin
                if (match_s) begin
                    fail_cnt_s = {FAIL_W{1'b0}};
                end else begin
                    fail_cnt_s = fail_inc_s;
                    if (state_s == LOCKED) lock_cnt_s = LOCK_LOAD;
                    else                   lock_cnt_s = lock_cnt_r;
                end
            end
            LOCKED: begin
                lock_cnt_s = lock_cnt_r - LOCK_ONE;
                if (state_s == IDLE) fail_cnt_s = {FAIL_W{1'b0}};
                else                 fail_cnt_s = fail_cnt_r;
            end
            default: begin
                fail_cnt_s = fail_cnt_r;
                lock_cnt_s = lock_cnt_r;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            granted_r  <= 1'b0;
            denied_r   <= 1'b0;
            aborted_r  <= 1'b0;
            busy_r     <= 1'b0;
            locked_r   <= 1'b0;
            sel_r      <= {SEL_W{1'b0}};
            fail_cnt_r <= {FAIL_W{1'b0}};
            lock_cnt_r <= {LOCK_W{1'b0}};
        end else begin
            granted_r  <= granted_s;
            denied_r   <= denied_s;
            aborted_r  <= aborted_s;
            busy_r     <= busy_s;
            locked_r   <= locked_s;
            sel_r      <= sel_s;
            fail_cnt_r <= fail_cnt_s;
            lock_cnt_r <= lock_cnt_s;
        end
    end

    assign granted  = granted_r;
    assign denied   = denied_r;
    assign aborted  = aborted_r;
    assign busy     = busy_r;
    assign locked   = locked_r;
    assign fail_cnt = fail_cnt_r;

endmodule
